// File: rtl/wb_unit.sv
// Writeback unit: selects integer/FP result sources, formats loads from cache data,
// and drives registered write ports for both register files. A sticky halt state ends execution.
module wb_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    localparam int OFF_W     = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            register_src,
    input  logic [1:0]            fregister_src,
    input  logic                  rd_we,
    input  logic                  frd_we,
    input  logic [REG_ADDR_W-1:0] rd_num,
    input  logic [REG_ADDR_W-1:0] frd_num,
    input  logic [1:0]            load_size,
    input  logic                  load_unsigned,
    input  logic [OFF_W-1:0]      byte_offset,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     falu_result,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     inst_addr,
    input  logic                  halted_in,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  frf_we,
    output logic [REG_ADDR_W-1:0] frf_waddr,
    output logic [DATA_W-1:0]     frf_wdata,
    output logic                  halted,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, HALT = 2'd2} state_t;

    typedef struct packed {
        logic [1:0]            register_src;
        logic [1:0]            fregister_src;
        logic                  rd_we;
        logic                  frd_we;
        logic [REG_ADDR_W-1:0] rd_num;
        logic [REG_ADDR_W-1:0] frd_num;
        logic [1:0]            load_size;
        logic                  load_unsigned;
        logic [OFF_W-1:0]      byte_offset;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     falu_result;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     inst_addr;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

    // Lane 0 is the most-significant byte; halfwords start on an even lane.
    function automatic logic [DATA_W-1:0] load_format(input logic [DATA_W-1:0] data,
                                                      input logic [1:0]        size,
                                                      input logic              uns,
                                                      input logic [OFF_W-1:0]  off);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = 8'h00;
        h = 16'h0000;
        for (int k = 0; k < DATA_W / 8; k++) begin
            b = (off == OFF_W'(k)) ? data[DATA_W-1-8*k -: 8] : b;
            h = ((k % 2 == 0) && ((off >> 1) == OFF_W'(k >> 1))) ? data[DATA_W-1-8*k -: 16] : h;
        end
        case (size)
            2'b00:   r = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
            2'b01:   r = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    instr_t                lat_q, lat_d, cur_s, sel_s;
    logic                  need_mem_s, commit_s;
    logic [DATA_W-1:0]     load_val_s, int_data_s, fp_data_s;
    logic                  rf_we_q, rf_we_d, frf_we_q, frf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d, frf_waddr_q, frf_waddr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d, frf_wdata_q, frf_wdata_d;

    assign cur_s = '{register_src, fregister_src, rd_we, frd_we, rd_num, frd_num, load_size,
                     load_unsigned, byte_offset, alu_result, falu_result, rs_data, inst_addr};
    // While waiting on memory the latched instruction drives the datapath.
    assign sel_s      = (state_q == WAIT_MEM) ? lat_q : cur_s;
    assign need_mem_s = (rd_we && (register_src == 2'b01)) || (frd_we && (fregister_src == 2'b10));
    assign load_val_s = load_format(mem_rdata, sel_s.load_size, sel_s.load_unsigned, sel_s.byte_offset);

    // Per-port source selection.
    always_comb begin
        int_data_s = alu_result;
        fp_data_s  = falu_result;
        case (sel_s.register_src)
            2'b00:   int_data_s = sel_s.alu_result;
            2'b01:   int_data_s = load_val_s;
            2'b10:   int_data_s = sel_s.inst_addr + DATA_W'(4);
            default: int_data_s = sel_s.falu_result;
        endcase
        case (sel_s.fregister_src)
            2'b01:   fp_data_s = sel_s.rs_data;
            2'b10:   fp_data_s = load_val_s;
            default: fp_data_s = sel_s.falu_result;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid && halted_in) begin
                    state_d = HALT;
                end else if (in_valid && need_mem_s) begin
                    state_d = WAIT_MEM;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: state_d = mem_valid ? IDLE : WAIT_MEM;
            HALT:     state_d = HALT;
            default:  state_d = IDLE;
        endcase
    end

    // Output/next-value logic for the write ports and the pending-load latch.
    always_comb begin
        commit_s = 1'b0;
        lat_d    = lat_q;
        case (state_q)
            IDLE: begin
                commit_s = in_valid && !halted_in && !need_mem_s;
                if (in_valid && !halted_in && need_mem_s) begin
                    lat_d = cur_s;
                end else begin
                    lat_d = lat_q;
                end
            end
            WAIT_MEM: commit_s = mem_valid;
            default:  commit_s = 1'b0;
        endcase
        rf_we_d     = commit_s && sel_s.rd_we && (sel_s.rd_num != {REG_ADDR_W{1'b0}});
        frf_we_d    = commit_s && sel_s.frd_we;
        rf_waddr_d  = rf_we_d  ? sel_s.rd_num  : rf_waddr_q;
        rf_wdata_d  = rf_we_d  ? int_data_s    : rf_wdata_q;
        frf_waddr_d = frf_we_d ? sel_s.frd_num : frf_waddr_q;
        frf_wdata_d = frf_we_d ? fp_data_s     : frf_wdata_q;
    end

    // Write-port and latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q       <= instr_t'({INSTR_W{1'b0}});
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= {REG_ADDR_W{1'b0}};
            rf_wdata_q  <= {DATA_W{1'b0}};
            frf_we_q    <= 1'b0;
            frf_waddr_q <= {REG_ADDR_W{1'b0}};
            frf_wdata_q <= {DATA_W{1'b0}};
        end else begin
            lat_q       <= lat_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            frf_we_q    <= frf_we_d;
            frf_waddr_q <= frf_waddr_d;
            frf_wdata_q <= frf_wdata_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q == WAIT_MEM);
    assign halted    = (state_q == HALT);
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign frf_we    = frf_we_q;
    assign frf_waddr = frf_waddr_q;
    assign frf_wdata = frf_wdata_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: a behavioural model checked every cycle plus literal expectations.
module tb_wb_unit;

    logic        clk, rst_n, in_valid, in_ready;
    logic [1:0]  register_src, fregister_src, load_size;
    logic        rd_we, frd_we, load_unsigned, halted_in, mem_valid;
    logic [4:0]  rd_num, frd_num;
    logic [1:0]  byte_offset;
    logic [31:0] alu_result, falu_result, rs_data, inst_addr, mem_rdata;
    logic        rf_we, frf_we, halted, busy;
    logic [4:0]  rf_waddr, frf_waddr;
    logic [31:0] rf_wdata, frf_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    wb_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .register_src(register_src), .fregister_src(fregister_src), .rd_we(rd_we), .frd_we(frd_we),
        .rd_num(rd_num), .frd_num(frd_num), .load_size(load_size), .load_unsigned(load_unsigned),
        .byte_offset(byte_offset), .alu_result(alu_result), .falu_result(falu_result),
        .rs_data(rs_data), .inst_addr(inst_addr), .halted_in(halted_in), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .frf_we(frf_we), .frf_waddr(frf_waddr), .frf_wdata(frf_wdata), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0]  rs, fs, ls, off;
        logic        rwe, fwe, lu;
        logic [4:0]  rd, frd;
        logic [31:0] alu, falu, rsd, ia;
    } ins_t;

    function automatic logic [31:0] loaded(ins_t i, logic [31:0] m);
        int k;
        logic [31:0] v;
        if (i.ls == 2'b00) begin
            k = int'(i.off);
            v = (m >> (8 * (3 - k))) & 32'h0000_00FF;
            if (!i.lu && v[7]) v = v | 32'hFFFF_FF00;
        end else if (i.ls == 2'b01) begin
            k = int'(i.off) & ~1;
            v = (m >> (8 * (2 - k))) & 32'h0000_FFFF;
            if (!i.lu && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = m;
        end
        return v;
    endfunction

    function automatic logic [31:0] int_val(ins_t i, logic [31:0] m);
        case (i.rs)
            2'b00:   return i.alu;
            2'b01:   return loaded(i, m);
            2'b10:   return i.ia + 32'd4;
            default: return i.falu;
        endcase
    endfunction

    function automatic logic [31:0] fp_val(ins_t i, logic [31:0] m);
        case (i.fs)
            2'b01:   return i.rsd;
            2'b10:   return loaded(i, m);
            default: return i.falu;
        endcase
    endfunction

    function automatic ins_t cur_ins();
        ins_t c;
        c.rs = register_src; c.fs = fregister_src; c.ls = load_size; c.off = byte_offset;
        c.rwe = rd_we; c.fwe = frd_we; c.lu = load_unsigned; c.rd = rd_num; c.frd = frd_num;
        c.alu = alu_result; c.falu = falu_result; c.rsd = rs_data; c.ia = inst_addr;
        return c;
    endfunction

    logic        m_halted, m_pend;
    ins_t        m_saved;
    logic        e_rf_we, e_frf_we;
    logic [4:0]  e_rf_waddr, e_frf_waddr;
    logic [31:0] e_rf_wdata, e_frf_wdata;

    always @(posedge clk or negedge rst_n) begin : model
        ins_t c;
        logic fire, wi;
        if (!rst_n) begin
            m_halted <= 1'b0; m_pend <= 1'b0;
            e_rf_we <= 1'b0; e_rf_waddr <= 5'd0; e_rf_wdata <= 32'd0;
            e_frf_we <= 1'b0; e_frf_waddr <= 5'd0; e_frf_wdata <= 32'd0;
        end else begin
            c = cur_ins();
            fire = 1'b0;
            if (!m_halted && m_pend) begin
                if (mem_valid) begin
                    c = m_saved;
                    fire = 1'b1;
                    m_pend <= 1'b0;
                end
            end else if (!m_halted && in_valid) begin
                if (halted_in) m_halted <= 1'b1;
                else if ((c.rwe && c.rs == 2'b01) || (c.fwe && c.fs == 2'b10)) begin
                    m_saved <= c;
                    m_pend  <= 1'b1;
                end else fire = 1'b1;
            end
            wi = fire && c.rwe && (c.rd != 5'd0);
            e_rf_we  <= wi;
            e_frf_we <= fire && c.fwe;
            if (wi) begin
                e_rf_waddr <= c.rd;
                e_rf_wdata <= int_val(c, mem_rdata);
            end
            if (fire && c.fwe) begin
                e_frf_waddr <= c.frd;
                e_frf_wdata <= fp_val(c, mem_rdata);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, rst_n && !m_halted && !m_pend});
        chk("m_busy",      {31'd0, busy},      {31'd0, m_pend});
        chk("m_halted",    {31'd0, halted},    {31'd0, m_halted});
        chk("m_rf_we",     {31'd0, rf_we},     {31'd0, e_rf_we});
        chk("m_rf_waddr",  {27'd0, rf_waddr},  {27'd0, e_rf_waddr});
        chk("m_rf_wdata",  rf_wdata,           e_rf_wdata);
        chk("m_frf_we",    {31'd0, frf_we},    {31'd0, e_frf_we});
        chk("m_frf_waddr", {27'd0, frf_waddr}, {27'd0, e_frf_waddr});
        chk("m_frf_wdata", frf_wdata,          e_frf_wdata);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear();
        register_src = 2'b00; fregister_src = 2'b00; load_size = 2'b00; byte_offset = 2'b00;
        rd_we = 1'b0; frd_we = 1'b0; load_unsigned = 1'b0; halted_in = 1'b0;
        rd_num = 5'd0; frd_num = 5'd0;
        alu_result = 32'd0; falu_result = 32'd0; rs_data = 32'd0; inst_addr = 32'd0;
    endtask

    task automatic go();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clear();
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
        clear();
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_rf_we",    {31'd0, rf_we},    32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_halted",   {31'd0, halted},   32'd0);
        tick();
        rst_n = 1'b1;

        // ALU write, accepted on the first edge after reset release
        rd_we = 1'b1; rd_num = 5'd3; alu_result = 32'h1234_5678;
        go();
        chk("alu_we",    {31'd0, rf_we}, 32'd1);
        chk("alu_waddr", {27'd0, rf_waddr}, 32'd3);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("alu_pulse", {31'd0, rf_we}, 32'd0);
        chk("alu_hold",  rf_wdata, 32'h1234_5678);

        // Signed byte load, memory answers 3 cycles late; a halt offered meanwhile is ignored
        rd_we = 1'b1; register_src = 2'b01; rd_num = 5'd5; byte_offset = 2'd1;
        go();
        for (int i = 0; i < 3; i++) begin
            chk("ld_busy",  {31'd0, busy}, 32'd1);
            chk("ld_ready", {31'd0, in_ready}, 32'd0);
            in_valid  = (i == 0);
            halted_in = (i == 0);
            if (i == 2) begin
                mem_rdata = 32'h11F2_3344;
                mem_valid = 1'b1;
            end
            tick();
        end
        mem_valid = 1'b0;
        chk("sb_we",    {31'd0, rf_we}, 32'd1);
        chk("sb_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("sb_wdata", rf_wdata, 32'hFFFF_FFF2);
        chk("sb_idle",  {31'd0, busy}, 32'd0);

        // Unsigned halfword, offset 3 (LSB ignored)
        rd_we = 1'b1; register_src = 2'b01; rd_num = 5'd6; load_size = 2'b01;
        load_unsigned = 1'b1; byte_offset = 2'd3;
        go();
        mem_rdata = 32'hAABB_8001; mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("uh_wdata", rf_wdata, 32'h0000_8001);

        // FP full load into FP register 0
        frd_we = 1'b1; fregister_src = 2'b10; frd_num = 5'd0; load_size = 2'b10;
        load_unsigned = 1'b1; byte_offset = 2'd2;
        go();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("fl_we",    {31'd0, frf_we}, 32'd1);
        chk("fl_wdata", frf_wdata, 32'hAABB_8001);
        chk("fl_rf_we", {31'd0, rf_we}, 32'd0);
        chk("fl_rfhold", rf_wdata, 32'h0000_8001);

        // rd_num 0 suppressed; inst_addr+4 wraps
        rd_we = 1'b1; rd_num = 5'd0; alu_result = 32'hDEAD_BEEF;
        go();
        chk("r0_we", {31'd0, rf_we}, 32'd0);
        rd_we = 1'b1; register_src = 2'b10; rd_num = 5'd9; inst_addr = 32'hFFFF_FFFC;
        go();
        chk("wrap_we",    {31'd0, rf_we}, 32'd1);
        chk("wrap_wdata", rf_wdata, 32'h0000_0000);

        // Dual write, independent sources
        rd_we = 1'b1; register_src = 2'b11; rd_num = 5'd4; falu_result = 32'hCAFE_F00D;
        frd_we = 1'b1; fregister_src = 2'b01; frd_num = 5'd2; rs_data = 32'h0BAD_C0DE;
        go();
        chk("dual_rf",  rf_wdata, 32'hCAFE_F00D);
        chk("dual_frf", frf_wdata, 32'h0BAD_C0DE);

        // Dual load, signed halfword lane 0; then unsigned byte lane 3
        rd_we = 1'b1; register_src = 2'b01; rd_num = 5'd7;
        frd_we = 1'b1; fregister_src = 2'b10; frd_num = 5'd8; load_size = 2'b01;
        go();
        mem_rdata = 32'h8123_4567; mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("dl_rf",  rf_wdata, 32'hFFFF_8123);
        chk("dl_frf", frf_wdata, 32'hFFFF_8123);
        rd_we = 1'b1; register_src = 2'b01; rd_num = 5'd10; load_unsigned = 1'b1; byte_offset = 2'd3;
        go();
        mem_rdata = 32'h1234_56F0; mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("ub_wdata", rf_wdata, 32'h0000_00F0);

        // Reset mid-WAIT_MEM drops the load
        rd_we = 1'b1; register_src = 2'b01; rd_num = 5'd11; load_size = 2'b10;
        go();
        chk("mr_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy0",  {31'd0, busy}, 32'd0);
        chk("mr_ready0", {31'd0, in_ready}, 32'd0);
        chk("mr_wdata0", rf_wdata, 32'd0);
        chk("mr_waddr0", {27'd0, rf_waddr}, 32'd0);
        chk("mr_fdata0", frf_wdata, 32'd0);
        mem_rdata = 32'h5555_5555; mem_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("mr_late_we", {31'd0, rf_we}, 32'd0);
        chk("mr_ready",   {31'd0, in_ready}, 32'd1);

        // Halt: no write, sticky, further instructions ignored
        rd_we = 1'b1; rd_num = 5'd3; alu_result = 32'h1111_1111; halted_in = 1'b1;
        go();
        chk("h_halted", {31'd0, halted}, 32'd1);
        chk("h_ready",  {31'd0, in_ready}, 32'd0);
        chk("h_we",     {31'd0, rf_we}, 32'd0);
        rd_we = 1'b1; rd_num = 5'd12; alu_result = 32'h2222_2222; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("h_ignore_we",   {31'd0, rf_we}, 32'd0);
        chk("h_ignore_data", rf_wdata, 32'd0);
        chk("h_sticky",      {31'd0, halted}, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, datapath width in bits; legal values are multiples of 32.
REQ-002 SHALL provide parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 SHALL derive OFF_W = log2(DATA_W/8) as the byte-offset width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream instruction present.
REQ-007 in_ready  out  1  unit accepts an instruction this cycle.
REQ-008 register_src  in  2  integer source select: 00 ALU, 01 memory, 10 inst_addr+4, 11 FP ALU.
REQ-009 fregister_src  in  2  FP source select: 00 FP ALU, 01 rs_data, 10 memory, 11 FP ALU.
REQ-010 rd_we, frd_we  in  1 each  integer / FP write requests.
REQ-011 rd_num, frd_num  in  REG_ADDR_W each  destination registers.
REQ-012 load_size  in  2  load size: 00 byte, 01 half, 10/11 full DATA_W.
REQ-013 load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
REQ-014 byte_offset  in  OFF_W  byte lane; lane 0 = most-significant byte.
REQ-015 alu_result, falu_result, rs_data, inst_addr  in  DATA_W each  operands.
REQ-016 halted_in  in  1  instruction is a halt.
REQ-017 mem_rdata  in  DATA_W  cache read data.
REQ-018 mem_valid  in  1  mem_rdata valid this cycle.
REQ-019 rf_we, rf_waddr, rf_wdata  out  1/REG_ADDR_W/DATA_W  integer write port, registered.
REQ-020 frf_we, frf_waddr, frf_wdata  out  1/REG_ADDR_W/DATA_W  FP write port, registered.
REQ-021 halted  out  1  sticky halt flag.
REQ-022 busy  out  1  high while in state WAIT_MEM.

Function
REQ-023 SHALL implement FSM states IDLE, WAIT_MEM and HALT.
REQ-024 in_ready SHALL be 1 only in IDLE.
REQ-025 An instruction SHALL be accepted in IDLE when in_valid=1.
REQ-026 Accepted instruction with halted_in=1: next state HALT, halted=1, no register writes.
REQ-027 Accepted instruction needing memory — rd_we and register_src=01, or frd_we and fregister_src=10: latch all control fields, next state WAIT_MEM, no write that edge.
REQ-028 Any other accepted instruction: write ports updated on the same edge (1-cycle latency), state stays IDLE.
REQ-029 In WAIT_MEM with mem_valid=1: latched instruction commits on that edge from mem_rdata, next state IDLE.
REQ-030 In WAIT_MEM with mem_valid=0: outputs hold, we=0.
REQ-031 mem_valid SHALL be ignored outside WAIT_MEM.
REQ-032 rf_we/frf_we SHALL be single-cycle pulses; rf_wdata/frf_wdata and addresses hold their last value when we=0.
REQ-033 Integer write with rd_num=0 SHALL be suppressed (rf_we=0); FP register 0 is writable.
REQ-034 Byte load: lane k = mem_rdata[DATA_W-1-8k -: 8], extended to DATA_W.
REQ-035 Halfword load: byte_offset LSB ignored; lanes k,k+1 form the halfword with lane k as MSB; extended.
REQ-036 Full load: mem_rdata passed unmodified; load_unsigned ignored.
REQ-037 inst_addr+4 SHALL wrap modulo 2^DATA_W.
REQ-038 One instruction may write both ports in the same cycle; each port selects its data independently.
REQ-039 HALT state: in_ready=0, no writes; exited only by reset.

Reset
REQ-040 rst_n=0 SHALL asynchronously force state IDLE, all outputs 0, halted=0 and busy=0, including mid-WAIT_MEM, dropping the pending load.
REQ-041 First acceptance SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-042 ALU op: register_src=00, rd_we=1, rd_num=3, alu_result=0x12345678 -> next edge rf_we=1, rf_waddr=3, rf_wdata=0x12345678; following cycle rf_we=0.
REQ-043 Signed byte load: offset=1, mem_rdata=0x11F23344, mem_valid 3 cycles late -> busy=1 for 3 cycles, in_ready=0, then rf_wdata=0xFFFFFFF2.
REQ-044 Unsigned half load: offset=3, mem_rdata=0xAABB8001 -> rf_wdata=0x00008001; FP load with fregister_src=10, full size -> frf_wdata=0xAABB8001, rf_we=0.
REQ-045 rd_num=0 ALU write -> rf_we stays 0; register_src=10, inst_addr=0xFFFFFFFC -> rf_wdata=0x00000000.
REQ-046 halted_in accepted -> halted=1, in_ready=0, further in_valid ignored; rst_n low mid-WAIT_MEM -> all outputs 0 immediately, late mem_valid produces no write.
